pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline package: FSM state encoding, flush-counter width and the
// default flush depth used by the decode stage and the hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam int STATE_W             = 2;
    localparam int FCNT_W              = 3;   // covers FLUSH_DEPTH up to 7
    localparam int FLUSH_DEPTH_DEFAULT = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RSVD     = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
//   master drives: decode sources, EX load/destination, redirect, mem_busy,
//                  counter clear
//   slave drives : PC / IF/ID / ID/EX controls, state, performance counters
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
);
    logic [REG_ADDR_WIDTH-1:0] id_read_address1;
    logic [REG_ADDR_WIDTH-1:0] id_read_address2;
    logic                      id_uses_rs2;
    logic                      ex_mem_rd_en;
    logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr;
    logic                      ex_redirect;
    logic                      mem_busy;
    logic                      cnt_clr;

    logic                      pc_wr_en;
    logic                      if_id_wr_en;
    logic                      if_id_flush;
    logic                      id_ex_hold;
    logic                      id_ex_bubble;
    logic [STATE_W-1:0]        state_out;
    logic [CNT_WIDTH-1:0]      stall_cnt;
    logic [CNT_WIDTH-1:0]      flush_cnt;

    modport master (
        output id_read_address1, id_read_address2, id_uses_rs2, ex_mem_rd_en,
               ex_reg_wr_addr, ex_redirect, mem_busy, cnt_clr,
        input  pc_wr_en, if_id_wr_en, if_id_flush, id_ex_hold, id_ex_bubble,
               state_out, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_read_address1, id_read_address2, id_uses_rs2, ex_mem_rd_en,
               ex_reg_wr_addr, ex_redirect, mem_busy, cnt_clr,
        output pc_wr_en, if_id_wr_en, if_id_flush, id_ex_hold, id_ex_bubble,
               state_out, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count this cycle (held at all-ones once reached)
//   clr        : synchronous clear, wins over inc
//   count      : current value
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush with a
// configurable bubble train, and memory-wait freeze, plus stall/flush
// performance counters.
//   clk, rst_n : clock, async active-low reset
//   hz         : hazard bundle (slave side), see pipe_hazard_ctrl_if
// Controls are combinational from the current state and inputs; the state,
// the return state, the flush down-counter and the counters are registered.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_DEPTH    = FLUSH_DEPTH_DEFAULT,
    parameter int CNT_WIDTH      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_DEPTH - 1);

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

    logic [REG_ADDR_WIDTH-1:0] ex_rd, id_rs1, id_rs2;
    logic lu;
    logic redirect_acc;
    logic pc_wr_en, if_id_wr_en, if_id_flush, id_ex_hold, id_ex_bubble;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    assign ex_rd  = hz.ex_reg_wr_addr;
    assign id_rs1 = hz.id_read_address1;
    assign id_rs2 = hz.id_read_address2;

    // Register zero is hard-wired, so a load targeting it never creates a hazard.
    assign lu = hz.ex_mem_rd_en && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (hz.id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        ret_d        = ret_q;
        fcnt_d       = fcnt_q;
        pc_wr_en     = 1'b1;
        if_id_wr_en  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        redirect_acc = 1'b0;

        // In reset the defaults above (plain RUN) are forced, ignoring inputs.
        if (rst_n) begin
            case (state_q)
                ST_RUN, ST_FLUSH: begin
                    if (hz.mem_busy) begin
                        // Freeze the front end; fcnt is left untouched so an
                        // interrupted flush resumes where it stopped.
                        pc_wr_en    = 1'b0;
                        if_id_wr_en = 1'b0;
                        id_ex_hold  = 1'b1;
                        ret_d       = state_q;
                        state_d     = ST_MEM_WAIT;
                    end else if (state_q == ST_FLUSH) begin
                        // Redirect and load-use are don't-cares while bubbling.
                        id_ex_bubble = 1'b1;
                        if (fcnt_q <= FCNT_W'(1)) begin
                            fcnt_d  = '0;
                            state_d = ST_RUN;
                        end else begin
                            fcnt_d = fcnt_q - FCNT_W'(1);
                        end
                    end else if (hz.ex_redirect) begin
                        if_id_wr_en  = 1'b0;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        redirect_acc = 1'b1;
                        fcnt_d       = FLUSH_LOAD;
                        state_d      = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;
                    end else if (lu) begin
                        pc_wr_en     = 1'b0;
                        if_id_wr_en  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    // Outputs stay frozen through the exit cycle too.
                    pc_wr_en    = 1'b0;
                    if_id_wr_en = 1'b0;
                    id_ex_hold  = 1'b1;
                    if (!hz.mem_busy) begin
                        state_d = ret_q;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            ret_q   <= ret_d;
            fcnt_q  <= fcnt_d;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_wr_en),
        .clr   (hz.cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_acc),
        .clr   (hz.cnt_clr),
        .count (flush_cnt)
    );

    assign hz.pc_wr_en     = pc_wr_en;
    assign hz.if_id_wr_en  = if_id_wr_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_hold   = id_ex_hold;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.state_out    = state_q;
    assign hz.stall_cnt    = stall_cnt;
    assign hz.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_DEPTH=2, 16-bit counters).
// Expected control vectors are queued when stimulus is applied and popped
// when the outputs are sampled mid-cycle; counters are checked just after
// the edge that updates them.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int AW = 5;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) hz_if ();

    pipe_hazard_ctrl #(
        .REG_ADDR_WIDTH (AW),
        .FLUSH_DEPTH    (2),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if)
    );

    // ctrl = {state_out, pc_wr_en, if_id_wr_en, if_id_flush, id_ex_hold, id_ex_bubble}
    typedef struct {
        string      tag;
        logic [6:0] ctrl;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [1:0] st, input logic pc,
                            input logic ifwr, input logic fl, input logic hd, input logic bb);
        exp_t e;
        e.tag  = tag;
        e.ctrl = {st, pc, ifwr, fl, hd, bb};
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_underflow: observed=empty expected=entry");
            return;
        end
        e = sb_q.pop_front();
        check(e.tag, {hz_if.state_out, hz_if.pc_wr_en, hz_if.if_id_wr_en,
                      hz_if.if_id_flush, hz_if.id_ex_hold, hz_if.id_ex_bubble}, e.ctrl);
    endtask

    // Called at posedge+1 with inputs already applied; samples mid-cycle and
    // returns at the next posedge+1.
    task automatic step(input string tag, input logic [1:0] st, input logic pc,
                        input logic ifwr, input logic fl, input logic hd, input logic bb);
        push_exp(tag, st, pc, ifwr, fl, hd, bb);
        #3;
        pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz_if.id_read_address1 = '0;
        hz_if.id_read_address2 = '0;
        hz_if.id_uses_rs2      = 1'b0;
        hz_if.ex_mem_rd_en     = 1'b0;
        hz_if.ex_reg_wr_addr   = '0;
        hz_if.ex_redirect      = 1'b0;
        hz_if.mem_busy         = 1'b0;
        hz_if.cnt_clr          = 1'b0;
    endtask

    task automatic set_ld(input logic rd_en, input logic [AW-1:0] wr, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2, input logic uses2);
        hz_if.ex_mem_rd_en     = rd_en;
        hz_if.ex_reg_wr_addr   = wr;
        hz_if.id_read_address1 = rs1;
        hz_if.id_read_address2 = rs2;
        hz_if.id_uses_rs2      = uses2;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with hostile inputs: outputs must still decode as plain RUN.
        clear_inputs();
        set_ld(1'b1, 5'd5, 5'd5, 5'd5, 1'b1);
        hz_if.ex_redirect = 1'b1;
        hz_if.mem_busy    = 1'b1;
        rst_n = 1'b0;
        #2;
        push_exp("reset_outputs", 2'd0, 1, 1, 0, 0, 0);
        pop_check();
        check("reset_stall_cnt", hz_if.stall_cnt, 0);
        check("reset_flush_cnt", hz_if.flush_cnt, 0);
        #10;
        rst_n = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;

        step("idle", 2'd0, 1, 1, 0, 0, 0);

        // Load-use through source 2.
        set_ld(1'b1, 5'd5, 5'd3, 5'd5, 1'b1);
        step("lu_rs2", 2'd0, 0, 0, 0, 0, 1);
        check("lu_rs2_stall_cnt", hz_if.stall_cnt, 1);
        clear_inputs();
        step("lu_rs2_after", 2'd0, 1, 1, 0, 0, 0);

        // Load-use through source 1 (source 2 unused).
        set_ld(1'b1, 5'd7, 5'd7, 5'd2, 1'b0);
        step("lu_rs1", 2'd0, 0, 0, 0, 0, 1);

        // Non-hazards: register zero, unused source 2, non-load producer.
        set_ld(1'b1, 5'd0, 5'd3, 5'd0, 1'b1);
        step("reg_zero", 2'd0, 1, 1, 0, 0, 0);
        set_ld(1'b1, 5'd9, 5'd1, 5'd9, 1'b0);
        step("rs2_unused", 2'd0, 1, 1, 0, 0, 0);
        set_ld(1'b0, 5'd9, 5'd9, 5'd9, 1'b1);
        step("not_load", 2'd0, 1, 1, 0, 0, 0);
        check("no_hazard_stall_cnt", hz_if.stall_cnt, 2);
        clear_inputs();

        // Single redirect: one flush cycle, two bubble cycles.
        hz_if.ex_redirect = 1'b1;
        step("redir", 2'd0, 1, 0, 1, 0, 1);
        check("redir_flush_cnt", hz_if.flush_cnt, 1);
        hz_if.ex_redirect = 1'b0;
        step("redir_flush", 2'd1, 1, 1, 0, 0, 1);
        step("redir_done", 2'd0, 1, 1, 0, 0, 0);

        // Memory wait during the FLUSH cycle: busy for 3 cycles (one seen in
        // FLUSH, two in MEM_WAIT) plus the frozen exit cycle, then the
        // interrupted bubble replays.
        hz_if.ex_redirect = 1'b1;
        step("nest_redir", 2'd0, 1, 0, 1, 0, 1);
        hz_if.ex_redirect = 1'b0;
        hz_if.mem_busy    = 1'b1;
        step("nest_fl_busy", 2'd1, 0, 0, 0, 1, 0);
        step("nest_mw1", 2'd2, 0, 0, 0, 1, 0);
        step("nest_mw2", 2'd2, 0, 0, 0, 1, 0);
        hz_if.mem_busy = 1'b0;
        step("nest_mw_exit", 2'd2, 0, 0, 0, 1, 0);
        step("nest_fl_resume", 2'd1, 1, 1, 0, 0, 1);
        step("nest_run", 2'd0, 1, 1, 0, 0, 0);
        check("nest_stall_cnt", hz_if.stall_cnt, 6);
        check("nest_flush_cnt", hz_if.flush_cnt, 2);

        // mem_busy outranks a redirect; the redirect is taken after the wait.
        hz_if.mem_busy    = 1'b1;
        hz_if.ex_redirect = 1'b1;
        step("busy_over_redir", 2'd0, 0, 0, 0, 1, 0);
        hz_if.mem_busy = 1'b0;
        step("wait_exit_redir", 2'd2, 0, 0, 0, 1, 0);
        check("wait_exit_flush_cnt", hz_if.flush_cnt, 2);
        step("redir_after_wait", 2'd0, 1, 0, 1, 0, 1);
        hz_if.ex_redirect = 1'b0;
        step("flush_after_wait", 2'd1, 1, 1, 0, 0, 1);
        step("run_after_wait", 2'd0, 1, 1, 0, 0, 0);
        check("wait_stall_cnt", hz_if.stall_cnt, 8);
        check("wait_flush_cnt", hz_if.flush_cnt, 3);

        // Redirect beats load-use; both are ignored in FLUSH.
        set_ld(1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
        hz_if.ex_redirect = 1'b1;
        step("redir_and_lu", 2'd0, 1, 0, 1, 0, 1);
        step("flush_ignores", 2'd1, 1, 1, 0, 0, 1);
        clear_inputs();
        step("run_after_both", 2'd0, 1, 1, 0, 0, 0);
        check("both_stall_cnt", hz_if.stall_cnt, 8);
        check("both_flush_cnt", hz_if.flush_cnt, 4);

        // Reset in the middle of FLUSH: no residual bubble afterwards.
        hz_if.ex_redirect = 1'b1;
        step("redir_pre_rst", 2'd0, 1, 0, 1, 0, 1);
        hz_if.ex_redirect = 1'b0;
        hz_if.mem_busy    = 1'b1;
        rst_n = 1'b0;
        #1;
        push_exp("rst_in_flush", 2'd0, 1, 1, 0, 0, 0);
        pop_check();
        check("rst_in_flush_stall_cnt", hz_if.stall_cnt, 0);
        check("rst_in_flush_flush_cnt", hz_if.flush_cnt, 0);
        #1;
        rst_n = 1'b1;
        hz_if.mem_busy = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst_flush", 2'd0, 1, 1, 0, 0, 0);

        // Reset in the middle of MEM_WAIT.
        hz_if.mem_busy = 1'b1;
        step("busy_pre_rst", 2'd0, 0, 0, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        push_exp("rst_in_wait", 2'd0, 1, 1, 0, 0, 0);
        pop_check();
        #1;
        rst_n = 1'b1;
        hz_if.mem_busy = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst_wait", 2'd0, 1, 1, 0, 0, 0);
        check("post_rst_stall_cnt", hz_if.stall_cnt, 0);

        // Saturation: hold a load-use stall to reach 16'hFFFE, then 3 more.
        set_ld(1'b1, 5'd6, 5'd6, 5'd0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        check("preload_stall_cnt", hz_if.stall_cnt, 32'h0000_FFFE);
        step("sat_lu1", 2'd0, 0, 0, 0, 0, 1);
        step("sat_lu2", 2'd0, 0, 0, 0, 0, 1);
        step("sat_lu3", 2'd0, 0, 0, 0, 0, 1);
        check("sat_stall_cnt", hz_if.stall_cnt, 32'h0000_FFFF);

        // Clear wins over a same-cycle stall increment.
        hz_if.cnt_clr = 1'b1;
        step("clr_with_lu", 2'd0, 0, 0, 0, 0, 1);
        check("clr_stall_cnt", hz_if.stall_cnt, 0);
        check("clr_flush_cnt", hz_if.flush_cnt, 0);
        clear_inputs();
        step("final_idle", 2'd0, 1, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
